// File: rtl/pipelined_chunk_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_chunk_adder_if
// Brief    : Operand and result valid/ready handshake bundle for the adder.
// Revision : 1.0
// ============================================================================
interface pipelined_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, A, B, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, A, B, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_chunk_adder
// Brief    : WIDTH-bit add/subtract, one CHUNK per pipeline stage, carry
//            registered between stages, single global stall enable.
// Revision : 1.0
// ============================================================================
module pipelined_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    pipelined_chunk_adder_if.slave  bus
);
    localparam int STAGES = WIDTH / CHUNK;

    // Index 0 is the conditioned-operand capture register; index k+1 holds
    // the beat after chunk k has been added, so index STAGES is the output.
    logic             r_valid [0:STAGES];
    logic             r_c     [0:STAGES];
    logic [WIDTH-1:0] r_s     [0:STAGES];
    logic [WIDTH-1:0] r_a     [0:STAGES-1];
    logic [WIDTH-1:0] r_b     [0:STAGES-1];
    logic             r_ovf;

    logic [CHUNK:0]   w_chunk [0:STAGES-1];
    logic [WIDTH-1:0] w_s     [0:STAGES-1];
    logic             w_msb_cin;
    logic             w_ovf;
    logic             w_en;

    assign w_en         = ~r_valid[STAGES] | bus.out_ready;
    assign bus.in_ready = w_en;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_chunk[k] = {1'b0, r_a[k][k*CHUNK +: CHUNK]}
                       + {1'b0, r_b[k][k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, r_c[k]};
            w_s[k]                   = r_s[k];
            w_s[k][k*CHUNK +: CHUNK] = w_chunk[k][CHUNK-1:0];
        end
        // Carry into the MSB recovered from the MSB sum bit and its operands.
        w_msb_cin = r_a[STAGES-1][WIDTH-1] ^ r_b[STAGES-1][WIDTH-1]
                  ^ w_s[STAGES-1][WIDTH-1];
        w_ovf     = w_msb_cin ^ w_chunk[STAGES-1][CHUNK];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_c[k]     <= 1'b0;
                r_s[k]     <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_valid[0] <= bus.in_valid;
            r_a[0]     <= bus.A;
            r_b[0]     <= bus.sub ? ~bus.B : bus.B;
            r_c[0]     <= bus.carry_in ^ bus.sub;
            r_s[0]     <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k+1] <= r_valid[k];
                r_c[k+1]     <= w_chunk[k][CHUNK];
                r_s[k+1]     <= w_s[k];
            end
            for (int k = 1; k < STAGES; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
            end
            r_ovf <= w_ovf;
        end
    end

    assign bus.out_valid = r_valid[STAGES];
    assign bus.sum       = r_s[STAGES];
    assign bus.carry_out = r_c[STAGES];
    assign bus.overflow  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_pipelined_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_chunk_adder
// Brief    : Directed-vector bench driving 16/4, 8/4 and 32/8 adders in lockstep.
// Revision : 1.0
// ============================================================================
module tb_pipelined_chunk_adder;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    logic        drv_valid = 1'b0;
    logic        drv_cin   = 1'b0;
    logic        drv_sub   = 1'b0;
    logic        drv_ready = 1'b1;
    logic [31:0] drv_a     = '0;
    logic [31:0] drv_b     = '0;
    int          sel       = 0;
    int          total     = 0;
    int          bad       = 0;

    logic        mo_valid, mo_ready, mo_co, mo_ov;
    logic [31:0] mo_sum;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_chunk_adder_if #(.WIDTH(16)) if16 ();
    pipelined_chunk_adder_if #(.WIDTH(8))  if8  ();
    pipelined_chunk_adder_if #(.WIDTH(32)) if32 ();

    assign if16.in_valid = drv_valid;     assign if8.in_valid = drv_valid;     assign if32.in_valid = drv_valid;
    assign if16.A        = drv_a[15:0];   assign if8.A        = drv_a[7:0];    assign if32.A        = drv_a;
    assign if16.B        = drv_b[15:0];   assign if8.B        = drv_b[7:0];    assign if32.B        = drv_b;
    assign if16.carry_in = drv_cin;       assign if8.carry_in = drv_cin;       assign if32.carry_in = drv_cin;
    assign if16.sub      = drv_sub;       assign if8.sub      = drv_sub;       assign if32.sub      = drv_sub;
    assign if16.out_ready = drv_ready;    assign if8.out_ready = drv_ready;    assign if32.out_ready = drv_ready;

    pipelined_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    pipelined_chunk_adder #(.WIDTH(8),  .CHUNK(4)) u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    pipelined_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

    always_comb begin
        mo_valid = if16.out_valid;
        mo_ready = if16.in_ready;
        mo_sum   = {16'h0, if16.sum};
        mo_co    = if16.carry_out;
        mo_ov    = if16.overflow;
        case (sel)
            1: begin
                mo_valid = if8.out_valid;  mo_ready = if8.in_ready;
                mo_sum   = {24'h0, if8.sum};
                mo_co    = if8.carry_out;  mo_ov    = if8.overflow;
            end
            2: begin
                mo_valid = if32.out_valid; mo_ready = if32.in_ready;
                mo_sum   = if32.sum;
                mo_co    = if32.carry_out; mo_ov    = if32.overflow;
            end
            default: ;
        endcase
    end

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic cin, logic sub,
                                logic [31:0] s, logic co, logic ov);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.s = s; v.co = co; v.ov = ov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (width sel %0d): got %h expected %h", name, sel, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive(input vec_t v);
        drv_a = v.a; drv_b = v.b; drv_cin = v.cin; drv_sub = v.sub; drv_valid = 1'b1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    // Watches the selected output port and checks hand-offs in order.
    task automatic collect(input vec_t v[$], output int first_cyc, output int last_cyc);
        int idx = 0;
        int waited = 0;
        first_cyc = 0;
        last_cyc  = 0;
        while (idx < v.size() && waited < 100) begin
            @(negedge clk);
            waited++;
            if (mo_valid && drv_ready) begin
                if (idx == 0) first_cyc = cyc;
                last_cyc = cyc;
                chk($sformatf("sum[%0d]", idx),      mo_sum, v[idx].s);
                chk($sformatf("carry_out[%0d]", idx), {31'h0, mo_co}, {31'h0, v[idx].co});
                chk($sformatf("overflow[%0d]", idx),  {31'h0, mo_ov}, {31'h0, v[idx].ov});
                idx++;
            end
        end
        chk("beats_out", idx, v.size());
    endtask

    task automatic stream(input vec_t v[$], input int lat);
        int acc_cyc = 0;
        int first_cyc = 0;
        int last_cyc = 0;
        fork
            begin
                for (int i = 0; i < v.size(); i++) begin
                    drive(v[i]);
                    step();
                    if (i == 0) acc_cyc = cyc;
                end
                drv_valid = 1'b0;
            end
            collect(v, first_cyc, last_cyc);
        join
        chk("latency", first_cyc - acc_cyc, lat);
        chk("back_to_back", last_cyc - first_cyc, v.size() - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v16[$];
        vec_t v8[$];
        vec_t v32[$];
        vec_t bp[$];
        vec_t fresh[$];
        int   bp_first;
        int   bp_last;
        int   stale;

        v16.push_back(mk(32'hFFFF, 32'hFFFF, 0, 0, 32'hFFFE, 1, 0));
        v16.push_back(mk(32'hFFFF, 32'h0000, 1, 0, 32'h0000, 1, 0));
        v16.push_back(mk(32'h0005, 32'h0007, 0, 1, 32'hFFFE, 0, 0));
        v16.push_back(mk(32'h8000, 32'h0001, 0, 1, 32'h7FFF, 1, 1));
        v16.push_back(mk(32'h7FFF, 32'h0001, 0, 0, 32'h8000, 0, 1));
        v16.push_back(mk(32'hAA55, 32'h55AA, 0, 0, 32'hFFFF, 0, 0));
        v16.push_back(mk(32'h0010, 32'h0003, 1, 1, 32'h000C, 1, 0));
        v16.push_back(mk(32'h0000, 32'h0000, 0, 1, 32'h0000, 1, 0));
        v16.push_back(mk(32'h1234, 32'h4321, 0, 0, 32'h5555, 0, 0));
        v16.push_back(mk(32'h8000, 32'h8000, 0, 0, 32'h0000, 1, 1));
        for (int i = 0; i < 8; i++)
            v16.push_back(mk(i * 32'h1111, 32'h0101, 0, 0, i * 32'h1111 + 32'h0101, 0, 0));

        v8.push_back(mk(32'hFF, 32'hFF, 0, 0, 32'hFE, 1, 0));
        v8.push_back(mk(32'hFF, 32'h00, 1, 0, 32'h00, 1, 0));
        v8.push_back(mk(32'h05, 32'h07, 0, 1, 32'hFE, 0, 0));
        v8.push_back(mk(32'h80, 32'h01, 0, 1, 32'h7F, 1, 1));
        v8.push_back(mk(32'h7F, 32'h01, 0, 0, 32'h80, 0, 1));
        v8.push_back(mk(32'hA5, 32'h5A, 0, 0, 32'hFF, 0, 0));
        for (int i = 0; i < 8; i++)
            v8.push_back(mk(i * 32'h11, 32'h01, 0, 0, i * 32'h11 + 32'h01, 0, 0));

        v32.push_back(mk(32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0));
        v32.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 1, 0));
        v32.push_back(mk(32'h00000005, 32'h00000007, 0, 1, 32'hFFFFFFFE, 0, 0));
        v32.push_back(mk(32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1));
        v32.push_back(mk(32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1));
        v32.push_back(mk(32'hAA55AA55, 32'h55AA55AA, 0, 0, 32'hFFFFFFFF, 0, 0));
        for (int i = 0; i < 8; i++)
            v32.push_back(mk(i * 32'h11111111, 32'h01010101, 0, 0,
                             i * 32'h11111111 + 32'h01010101, 0, 0));

        for (int i = 0; i < 6; i++)
            bp.push_back(mk(i * 32'h1000 + 32'h1, 32'h0F0F, 0, 0, i * 32'h1000 + 32'h0F10, 0, 0));
        fresh.push_back(mk(32'h0F0F, 32'h00F1, 0, 0, 32'h1000, 0, 0));

        // Reset state
        idle(3);
        chk("rst_out_valid", {31'h0, mo_valid}, 32'h0);
        chk("rst_sum",       mo_sum, 32'h0);
        chk("rst_carry_out", {31'h0, mo_co}, 32'h0);
        chk("rst_overflow",  {31'h0, mo_ov}, 32'h0);
        chk("rst_in_ready",  {31'h0, mo_ready}, 32'h1);
        rst = 1'b0;
        idle(2);

        // Functional table streamed back to back on the 16-bit adder
        sel = 0;
        stream(v16, 4);
        idle(8);

        // Backpressure: fill the pipe with out_ready low, then hold three cycles
        drv_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(bp[i]);
            step();
        end
        drive(bp[5]);
        chk("bp_full_valid", {31'h0, mo_valid}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_in_ready[%0d]", i), {31'h0, mo_ready}, 32'h0);
            chk($sformatf("bp_hold_sum[%0d]", i), mo_sum, bp[0].s);
            chk($sformatf("bp_hold_co[%0d]", i),  {31'h0, mo_co}, 32'h0);
            chk($sformatf("bp_hold_ov[%0d]", i),  {31'h0, mo_ov}, 32'h0);
        end
        drv_ready = 1'b1;
        fork
            begin
                step();
                drv_valid = 1'b0;
            end
            collect(bp, bp_first, bp_last);
        join
        chk("bp_drain_back_to_back", bp_last - bp_first, 5);
        idle(8);

        // Asynchronous reset between edges with beats in flight
        for (int i = 0; i < 5; i++) begin
            drive(bp[i]);
            step();
        end
        drv_valid = 1'b0;
        chk("pre_rst_valid", {31'h0, mo_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'h0, mo_valid}, 32'h0);
        chk("async_rst_sum",   mo_sum, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mo_valid) stale++;
        end
        chk("no_stale_beats", stale, 0);
        step();
        stream(fresh, 4);
        idle(8);

        // Other parametrisations
        sel = 1;
        pulse_reset();
        stream(v8, 2);
        idle(8);

        sel = 2;
        pulse_reset();
        stream(v32, 4);
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
